// File: rtl/task_frame_arbiter_pkg.sv
// Shared types and helpers for the task-input frame arbiter.
package task_frame_arbiter_pkg;

  typedef enum logic [1:0] {
    s_IDLE      = 2'd0,
    s_XFER      = 2'd1,
    s_DRAIN     = 2'd2,
    s_WAIT_DONE = 2'd3
  } arb_state_e;

  // Bit width for indexing n items; never below one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/task_frame_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after the pointer, wrapping.
module rr_arbiter
  import task_frame_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]                i_req,
  input  logic [clog2_min1(N)-1:0]    i_ptr,
  output logic [clog2_min1(N)-1:0]    o_gnt_id,
  output logic                        o_any
);

  localparam int W = clog2_min1(N);

  always_comb begin
    int idx;
    idx      = 0;
    o_gnt_id = '0;
    o_any    = |i_req;
    // Walk from the farthest offset back so the nearest requester is written last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(i_ptr) + i) % N;
      if (i_req[idx]) o_gnt_id = W'(idx);
    end
  end

endmodule

// File: rtl/task_frame_arbiter.sv
// Round-robin frame arbiter: one whole frame per grant, next grant held until downstream completion.
module task_frame_arbiter
  import task_frame_arbiter_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_WORDS      = 243,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_SRC-1:0]               i_req,
  input  logic [NUM_SRC-1:0]               i_tvalid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]    i_tdata,
  input  logic [NUM_SRC-1:0]               i_tlast,
  output logic [NUM_SRC-1:0]               o_tready,
  output logic                             o_tvalid,
  output logic [DATA_WIDTH-1:0]            o_tdata,
  output logic                             o_tlast,
  input  logic                             i_tready,
  input  logic                             i_output_last,
  output logic [$clog2(NUM_SRC)-1:0]       o_grant_id,
  output logic                             o_busy,
  output logic                             o_frame_err,
  output logic                             o_timeout
);

  localparam int GW = clog2_min1(NUM_SRC);
  localparam int WW = $clog2(MAX_WORDS + 1);
  localparam int TW = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] LAST_WORD = WW'(MAX_WORDS - 1);
  localparam logic [TW-1:0] LAST_TMO  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] LAST_SRC  = GW'(NUM_SRC - 1);

  // Stream handshake: a beat moves on any cycle where valid and ready are both high;
  // the source holds data/last while valid is up, and ready never waits on valid.
  arb_state_e    state, state_next;
  logic [GW-1:0] ptr, grant, arb_id;
  logic          arb_any;
  logic [WW-1:0] word_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          src_valid, src_last, hs, at_limit, tmo_hit, leave_wait;

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .i_req    (i_req),
    .i_ptr    (ptr),
    .o_gnt_id (arb_id),
    .o_any    (arb_any)
  );

  assign src_valid  = i_tvalid[grant];
  assign src_last   = i_tlast[grant];
  assign hs         = (state == s_XFER) && src_valid && i_tready;
  assign at_limit   = (word_cnt == LAST_WORD);
  assign tmo_hit    = (tmo_cnt == LAST_TMO);
  assign leave_wait = (state == s_WAIT_DONE) && (i_output_last || tmo_hit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= s_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      s_IDLE:      if (arb_any) state_next = s_XFER;
      s_XFER:      if (hs) begin
                     if (src_last)      state_next = s_WAIT_DONE;
                     else if (at_limit) state_next = s_DRAIN;
                   end
      s_DRAIN:     if (src_valid && src_last) state_next = s_WAIT_DONE;
      s_WAIT_DONE: if (leave_wait) state_next = s_IDLE;
      default:     state_next = s_IDLE;
    endcase
  end

  always_comb begin
    o_tready    = '0;
    o_tvalid    = 1'b0;
    o_tdata     = '0;
    o_tlast     = 1'b0;
    o_frame_err = 1'b0;
    o_timeout   = 1'b0;
    case (state)
      s_XFER: begin
        o_tready[grant] = i_tready;
        o_tvalid        = src_valid;
        o_tdata         = i_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
        o_tlast         = src_valid && (src_last || at_limit);
        o_frame_err     = hs && at_limit && !src_last;
      end
      s_DRAIN:     o_tready[grant] = 1'b1;
      // Completion wins over expiry when both land on the same cycle.
      s_WAIT_DONE: o_timeout = tmo_hit && !i_output_last;
      default: ;
    endcase
  end

  assign o_busy     = (state != s_IDLE);
  assign o_grant_id = grant;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant    <= '0;
      ptr      <= '0;
      word_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (state == s_IDLE && arb_any) begin
        grant    <= arb_id;
        word_cnt <= '0;
      end else if (hs) begin
        word_cnt <= word_cnt + WW'(1);
      end
      if (leave_wait) ptr <= (grant == LAST_SRC) ? '0 : grant + GW'(1);
      if (state != s_WAIT_DONE || leave_wait) tmo_cnt <= '0;
      else                                    tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_task_frame_arbiter.sv
// Randomized bench for task_frame_arbiter against a frame-level round-robin model.
module tb_task_frame_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MAX = 243;
  localparam int TMO = 4096;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    i_req, i_tvalid, i_tlast, o_tready;
  logic [N*DW-1:0] i_tdata;
  logic            o_tvalid, o_tlast, i_tready, i_output_last;
  logic [DW-1:0]   o_tdata;
  logic [1:0]      o_grant_id;
  logic            o_busy, o_frame_err, o_timeout;

  task_frame_arbiter #(
    .NUM_SRC(N), .DATA_WIDTH(DW), .MAX_WORDS(MAX), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_tvalid(i_tvalid),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .o_tready(o_tready),
    .o_tvalid(o_tvalid), .o_tdata(o_tdata), .o_tlast(o_tlast),
    .i_tready(i_tready), .i_output_last(i_output_last),
    .o_grant_id(o_grant_id), .o_busy(o_busy),
    .o_frame_err(o_frame_err), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int             n_cmp = 0;
  int             n_err = 0;
  int             ptr_m = 0;
  int             flen;
  int             kidx [N];
  logic [DW-1:0]  base [N];
  logic [DW:0]    exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] req, input int p);
    for (int i = 0; i < N; i++)
      if (req[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic drive_sources(input int mode);
    for (int s = 0; s < N; s++) begin
      i_tvalid[s]           = (kidx[s] < flen) && ($urandom_range(0, 3) != 0);
      i_tdata[s*DW +: DW]   = base[s] + DW'(kidx[s]);
      i_tlast[s]            = (kidx[s] == flen - 1);
    end
    case (mode)
      0:       i_tready = 1'($urandom_range(0, 1));
      1:       i_tready = ~i_tready;
      default: i_tready = 1'b1;
    endcase
    i_req = N'($urandom);
  endtask

  task automatic run_frame(input logic [N-1:0] pat, input int l, input int mode,
                           input int wait_d, input bit use_ol);
    int g, exp_n, out_idx, cyc, n;
    logic [N-1:0] adv;
    logic [DW:0] e;
    bit hs_out, exp_err, seen;
    g     = rr_pick(pat, ptr_m);
    flen  = l;
    exp_n = (l < MAX) ? l : MAX;
    exp_q.delete();
    for (int s = 0; s < N; s++) begin
      base[s] = DW'($urandom);
      kidx[s] = 0;
    end
    for (int k = 0; k < exp_n; k++) exp_q.push_back({k == exp_n - 1, base[g] + DW'(k)});
    drive_sources(2);
    i_req = pat;
    @(posedge clk); #1;
    check_eq("grant", o_grant_id, g);
    check_eq("busy_xfer", o_busy, 1);
    i_req   = N'($urandom);
    out_idx = 0;
    cyc     = 0;
    while (kidx[g] < l && cyc < l * 10 + 50) begin
      @(negedge clk);
      hs_out  = o_tvalid && i_tready;
      exp_err = hs_out && (out_idx == MAX - 1) && (l > MAX);
      check_eq("grant_hold", o_grant_id, g);
      check_eq("tready_other", o_tready & ~(N'(1) << g), 0);
      check_eq("frame_err", o_frame_err, exp_err);
      if (hs_out) begin
        if (exp_q.size() == 0) begin
          check_eq("beat_count", out_idx + 1, exp_n);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat", {o_tlast, o_tdata}, e);
        end
        out_idx++;
      end
      for (int s = 0; s < N; s++) adv[s] = i_tvalid[s] && o_tready[s];
      @(posedge clk); #1;
      for (int s = 0; s < N; s++) if (adv[s]) kidx[s]++;
      drive_sources(mode);
      cyc++;
    end
    check_eq("frame_consumed", kidx[g], l);
    check_eq("beats_total", out_idx, exp_n);
    i_tvalid = '0;
    i_tlast  = '0;
    if (use_ol) begin
      for (int k = 0; k < wait_d; k++) begin
        @(negedge clk);
        check_eq("wait_busy", o_busy, 1);
        check_eq("wait_quiet", {o_tready, o_tvalid, o_timeout}, 0);
        @(posedge clk); #1;
        i_req = N'($urandom);
      end
      i_output_last = 1'b1;
      i_req         = '0;
      @(negedge clk);
      check_eq("timeout_on_done", o_timeout, 0);
      @(posedge clk); #1;
      i_output_last = 1'b0;
    end else begin
      i_req = '0;
      n     = 0;
      seen  = 1'b0;
      while (!seen && n < TMO + 100) begin
        @(negedge clk);
        n++;
        if (o_timeout) seen = 1'b1;
      end
      check_eq("timeout_cycle", n, TMO);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_eq("idle_after", o_busy, 0);
    check_eq("timeout_idle", o_timeout, 0);
    ptr_m = (g + 1) % N;
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_frame();
    int g;
    g        = rr_pick(4'hF, ptr_m);
    flen     = 10;
    base[g]  = DW'($urandom);
    i_req    = 4'hF;
    i_tvalid = N'(1) << g;
    i_tready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_tdata[g*DW +: DW] = base[g] + DW'(k);
      @(posedge clk); #1;
    end
    i_tdata[g*DW +: DW] = base[g] + DW'(2);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_pre_valid", o_tvalid, 1);
    check_eq("rst_pre_data", o_tdata, base[g] + DW'(2));
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_tready", o_tready, 0);
    check_eq("rst_tvalid", o_tvalid, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_grant", o_grant_id, 0);
    i_req    = '0;
    i_tvalid = '0;
    ptr_m    = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_req = '0; i_tvalid = '0; i_tdata = '0; i_tlast = '0;
    i_tready = 1'b0; i_output_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", {o_tready, o_tvalid, o_tdata, o_tlast, o_grant_id,
                               o_busy, o_frame_err, o_timeout}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("reset_idle", o_busy, 0);

    run_frame(4'b0001, 5, 2, 1, 1'b1);
    for (int i = 0; i < 5; i++) run_frame(4'b1111, $urandom_range(1, 12), 0, $urandom_range(0, 3), 1'b1);
    run_frame(4'b1111, 10, 1, 0, 1'b1);
    for (int i = 0; i < 8; i++)
      run_frame(N'($urandom_range(1, 15)), $urandom_range(1, 20), $urandom_range(0, 2),
                $urandom_range(0, 3), 1'b1);
    run_frame(4'b1010, MAX, 2, 2, 1'b1);
    run_frame(4'b1111, 300, 2, 1, 1'b1);
    run_frame(4'b0110, 4, 0, 0, 1'b0);
    run_frame(4'b1111, 3, 2, TMO - 1, 1'b1);
    reset_mid_frame();
    run_frame(4'b0010, 6, 0, 1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
